// File: rtl/operand_batch_sequencer_if.sv
// Handshake and operand bus between the batch sequencer and its user.
// The slave side is the sequencer; the master side drives entry pulses and read indices.
interface operand_batch_sequencer_if #(
    parameter int W = 16
);
    logic         push;
    logic [W-1:0] data_in;
    logic         clear;
    logic         ack;
    logic         core_done;
    logic         core_start;
    logic [4:0]   count;
    logic         busy;
    logic         batch_ready;
    logic         timeout_err;
    logic         overrun_err;
    logic [4:0]   rd_idx;
    logic [W-1:0] rd_data;

    modport master (
        output push, data_in, clear, ack, core_done, rd_idx,
        input  core_start, count, busy, batch_ready, timeout_err, overrun_err, rd_data
    );

    modport slave (
        input  push, data_in, clear, ack, core_done, rd_idx,
        output core_start, count, busy, batch_ready, timeout_err, overrun_err, rd_data
    );
endinterface

// File: rtl/operand_batch_sequencer.sv
// Collects N_OPS operands, launches the coprocessor once, waits for done or timeout,
// then holds the batch readable until the user acknowledges.
module operand_batch_sequencer #(
    parameter int N_OPS       = 10,
    parameter int W           = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input logic                      clk,
    input logic                      rst,
    operand_batch_sequencer_if.slave bus
);
    localparam int          IDX_W    = (N_OPS > 1) ? $clog2(N_OPS) : 1;
    localparam logic [4:0]  N_OPS_C  = 5'(N_OPS);
    localparam logic [4:0]  LAST_IDX = 5'(N_OPS - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        LAUNCH = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    count_q, count_d;
    logic [15:0]   wait_q, wait_d;
    logic          timeout_q, timeout_d;
    logic          overrun_q, overrun_d;
    logic          core_start_q, core_start_d;
    logic          busy_q, busy_d;
    logic          ready_q, ready_d;
    logic [W-1:0]  opbuf_q [N_OPS];
    logic [W-1:0]  opbuf_d [N_OPS];
    logic          accepting;

    assign accepting = (state_q == IDLE) || (state_q == FILL);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        overrun_d = overrun_q;
        opbuf_d   = opbuf_q;

        if (bus.clear) begin
            state_d   = IDLE;
            count_d   = '0;
            wait_d    = '0;
            timeout_d = 1'b0;
            overrun_d = 1'b0;
        end else begin
            // A push is only legal while collecting; anything else is a sticky overrun.
            if (bus.push && !accepting) begin
                overrun_d = 1'b1;
            end
            case (state_q)
                IDLE, FILL: begin
                    if (bus.push) begin
                        opbuf_d[count_q[IDX_W-1:0]] = bus.data_in;
                        count_d = count_q + 5'd1;
                        state_d = (count_q == LAST_IDX) ? LAUNCH : FILL;
                    end
                end
                LAUNCH: begin
                    state_d = WAIT;
                    wait_d  = '0;
                end
                WAIT: begin
                    wait_d = wait_q + 16'd1;
                    // Done takes precedence over a timeout landing in the same cycle.
                    if (bus.core_done) begin
                        state_d   = DONE;
                        timeout_d = 1'b0;
                    end else if (wait_q == TMO_LAST) begin
                        state_d   = DONE;
                        timeout_d = 1'b1;
                    end
                end
                DONE: begin
                    if (bus.ack) begin
                        state_d   = IDLE;
                        count_d   = '0;
                        timeout_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        core_start_d = (state_d == LAUNCH);
        busy_d       = (state_d == LAUNCH) || (state_d == WAIT);
        ready_d      = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            wait_q       <= '0;
            timeout_q    <= 1'b0;
            overrun_q    <= 1'b0;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b0;
            for (int i = 0; i < N_OPS; i++) begin
                opbuf_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            wait_q       <= wait_d;
            timeout_q    <= timeout_d;
            overrun_q    <= overrun_d;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
            opbuf_q      <= opbuf_d;
        end
    end

    // Indices past the end of the batch read as zero rather than aliasing.
    always_comb begin
        bus.rd_data = '0;
        if (bus.rd_idx < N_OPS_C) begin
            bus.rd_data = opbuf_q[bus.rd_idx[IDX_W-1:0]];
        end
    end

    assign bus.core_start  = core_start_q;
    assign bus.count       = count_q;
    assign bus.busy        = busy_q;
    assign bus.batch_ready = ready_q;
    assign bus.timeout_err = timeout_q;
    assign bus.overrun_err = overrun_q;
endmodule

// File: doc/operand_batch_sequencer.md
Name: operand_batch_sequencer

Overview:
Front-end controller for the combinational coprocessor. It collects a batch of N_OPS operand words from single-cycle, already edge-detected entry pulses. When the batch is full it fires one start pulse to the core and waits for done, with a timeout. It then holds the batch readable and reports status until the user acknowledges, sequencing the entry-count resource together with the core handshake.

Parameters:
N_OPS, 10, operands per batch (2..31)
W, 16, operand width in bits
TIMEOUT_CYC, 255, max cycles in WAIT before declaring timeout (1..65535)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
push  in  1  one-cycle entry pulse; capture data_in
data_in  in  W  operand value captured on push
clear  in  1  abort batch, return to IDLE
ack  in  1  user acknowledge in DONE
core_done  in  1  core completion strobe
core_start  out  1  one-cycle start pulse to core
count  out  5  operands captured in current batch
busy  out  1  high in LAUNCH or WAIT
batch_ready  out  1  high in DONE
timeout_err  out  1  high in DONE if entered via timeout
overrun_err  out  1  sticky: push arrived while not accepting
rd_idx  in  5  operand read index
rd_data  out  W  operand buffer[rd_idx], combinational read; 0 if rd_idx >= N_OPS

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; count=0, core_start=0, busy=0, batch_ready=0, timeout_err=0, overrun_err=0, wait counter=0, all buffer words=0. rst overrides every other input.
- Priority per cycle: rst > clear > state logic.
- clear=1: state=IDLE, count=0, core_start=0, timeout_err=0, overrun_err=0, wait counter=0. Buffer contents are kept.
- IDLE / FILL (accepting):
  - push: buffer[count] <= data_in; count <= count+1.
  - FILL is entered on the first push.
  - When the captured word is number N_OPS (count was N_OPS-1), next state is LAUNCH and count = N_OPS.
  - No push: hold.
- LAUNCH: lasts exactly 1 cycle with core_start=1, then WAIT, wait counter=0. core_start is high only in LAUNCH and never for more than 1 consecutive cycle.
- WAIT:
  - Wait counter increments each cycle.
  - core_done=1 → DONE, timeout_err=0.
  - Else if wait counter == TIMEOUT_CYC-1 → DONE, timeout_err=1.
  - core_done coincident with the timeout cycle: done wins, timeout_err=0.
  - core_done outside WAIT is ignored.
- DONE: batch_ready=1; buffer and count are held.
  - ack → IDLE, count=0, timeout_err=0 next cycle.
  - push coincident with ack: the push is ignored and flagged as overrun.
- Overrun: push in LAUNCH, WAIT or DONE sets overrun_err=1 (sticky). Buffer and count are unchanged. Cleared only by rst or clear.
- ack outside DONE is ignored.
- Latency: from the N_OPS-th push edge, core_start is high on the next cycle (1 cycle).
- count width is 5 bits; never exceeds N_OPS; no wrap-around.
- busy = (state==LAUNCH || state==WAIT).

Test Plan:
1. Normal batch: rst, then 10 pushes with data 1..10 spaced 2 cycles → count reaches 10, core_start high exactly 1 cycle after the 10th push; core_done 5 cycles later → batch_ready=1, timeout_err=0; rd_idx 0..9 reads 1..10; ack → count=0, IDLE.
2. Timeout: full batch, core_done never asserted → batch_ready rises after exactly TIMEOUT_CYC cycles in WAIT with timeout_err=1; ack clears timeout_err.
3. Done on the timeout cycle: with TIMEOUT_CYC=4, core_done on the 4th WAIT cycle → timeout_err=0, batch_ready=1.
4. Overrun: push during WAIT and DONE → overrun_err=1, count stays 10, buffer[9] unchanged; push with ack in DONE → ignored, overrun_err=1; clear → overrun_err=0, count=0.
5. Mid-operation abort: 4 pushes, then clear → count=0, IDLE, no core_start; clear during WAIT → busy=0 next cycle, later core_done ignored.
6. Reset mid-batch: rst during FILL with count=6 → all outputs 0 the next cycle; rd_data=0 for all indices; rd_idx=12 reads 0.
